mbscore_vec_int_ctrl: RTL and testbench

Parametrised vectored interrupt controller for the MBScore CPU. It latches up to NUM_SRC interrupt sources and masks them per source. It selects the highest-priority eligible source, stalls the pipeline with a stall/acknowledge handshake, then issues a one-cycle vectored jump. It blocks further interrupts until the core signals end-of-interrupt. It sits between SoC peripherals and the core fetch/PC logic.

---
 rtl/mbscore_vec_int_ctrl_pkg.sv | 16 +
 rtl/mbscore_vec_int_ctrl_if.sv | 34 +++
 rtl/mbscore_prio_enc.sv | 25 ++
 rtl/mbscore_vec_int_ctrl.sv | 98 +++++++++
 tb/tb_mbscore_vec_int_ctrl.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/mbscore_vec_int_ctrl_pkg.sv
// rtl/mbscore_vec_int_ctrl_pkg.sv - shared types and defaults for the MBScore vectored interrupt controller
// Purpose: FSM state encoding and default vector table placement.
// Ports: none (package).
package mbscore_vec_int_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_STALL   = 2'd1,
    ST_JUMP    = 2'd2,
    ST_SERVICE = 2'd3
  } state_t;

  localparam logic [31:0] DEF_VEC_BASE        = 32'h0000_0100;
  localparam int          DEF_VEC_STRIDE_LOG2 = 4;

endpackage

// File: rtl/mbscore_vec_int_ctrl_if.sv
// rtl/mbscore_vec_int_ctrl_if.sv - request/handshake bundle between SoC/core and the interrupt controller
// Purpose: groups interrupt requests, core handshake and vectoring outputs.
// Ports (signals):
//   irq_src, int_en_n, irq_mask, stall_ack, eoi       : core/SoC -> controller
//   stop, setINTR, int_jump, int_addr, int_id,
//   irq_pending                                        : controller -> core
// Modports: master = core/SoC side, slave = controller.
interface mbscore_vec_int_ctrl_if #(
  parameter int NUM_SRC    = 8,
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = $clog2(NUM_SRC)
);
  logic [NUM_SRC-1:0]    irq_src;
  logic                  int_en_n;
  logic [NUM_SRC-1:0]    irq_mask;
  logic                  stall_ack;
  logic                  eoi;
  logic                  stop;
  logic                  setINTR;
  logic                  int_jump;
  logic [ADDR_WIDTH-1:0] int_addr;
  logic [ID_WIDTH-1:0]   int_id;
  logic [NUM_SRC-1:0]    irq_pending;

  modport master (
    output irq_src, int_en_n, irq_mask, stall_ack, eoi,
    input  stop, setINTR, int_jump, int_addr, int_id, irq_pending
  );

  modport slave (
    input  irq_src, int_en_n, irq_mask, stall_ack, eoi,
    output stop, setINTR, int_jump, int_addr, int_id, irq_pending
  );
endinterface

// File: rtl/mbscore_prio_enc.sv
// rtl/mbscore_prio_enc.sv - lowest-index priority encoder with valid flag
// Purpose: returns the index of the lowest set request bit.
// Ports: req (in, NUM_SRC), id (out, ID_WIDTH), valid (out, any request set).
module mbscore_prio_enc #(
  parameter int NUM_SRC  = 8,
  parameter int ID_WIDTH = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0]  req,
  output logic [ID_WIDTH-1:0] id,
  output logic                valid
);

  // Scan from the top down so the lowest set index is written last and wins.
  always_comb begin
    id    = '0;
    valid = 1'b0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        id    = ID_WIDTH'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mbscore_vec_int_ctrl.sv
// rtl/mbscore_vec_int_ctrl.sv - vectored interrupt controller top for the MBScore core
// Purpose: latches/masks sources, stalls the pipeline, issues a one-cycle vectored
//          jump, then blocks further interrupts until end-of-interrupt.
// Ports: clk, rst_n (async active-low); bus (slave modport, see interface file).
module mbscore_vec_int_ctrl
  import mbscore_vec_int_ctrl_pkg::*;
#(
  parameter int                    NUM_SRC         = 8,
  parameter int                    ADDR_WIDTH      = 32,
  parameter logic [ADDR_WIDTH-1:0] VEC_BASE        = ADDR_WIDTH'(DEF_VEC_BASE),
  parameter int                    VEC_STRIDE_LOG2 = DEF_VEC_STRIDE_LOG2,
  parameter logic [NUM_SRC-1:0]    EDGE_MASK       = {NUM_SRC{1'b1}},
  parameter int                    ID_WIDTH        = $clog2(NUM_SRC)
) (
  input logic                   clk,
  input logic                   rst_n,
  mbscore_vec_int_ctrl_if.slave bus
);

  state_t                state_q, state_d;
  logic [NUM_SRC-1:0]    hist_q;
  logic [NUM_SRC-1:0]    pend_q, pend_d;
  logic [NUM_SRC-1:0]    elig;
  logic [ID_WIDTH-1:0]   win_id;
  logic                  win_valid;
  logic [ID_WIDTH-1:0]   id_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  in_service;

  assign elig       = pend_q & ~bus.irq_mask & {NUM_SRC{~bus.int_en_n}};
  assign in_service = (state_q == ST_JUMP) || (state_q == ST_SERVICE);

  mbscore_prio_enc #(
    .NUM_SRC  (NUM_SRC),
    .ID_WIDTH (ID_WIDTH)
  ) u_prio_enc (
    .req   (elig),
    .id    (win_id),
    .valid (win_valid)
  );

  // Edge sources: a fresh edge beats the JUMP-cycle clear. Level sources
  // mirror the input, but the one in service reads 0 so it cannot re-enter.
  always_comb begin
    pend_d = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (EDGE_MASK[i]) begin
        pend_d[i] = (bus.irq_src[i] & ~hist_q[i]) |
                    (pend_q[i] & ~((state_q == ST_JUMP) && (id_q == ID_WIDTH'(i))));
      end else begin
        pend_d[i] = bus.irq_src[i] & ~(in_service && (id_q == ID_WIDTH'(i)));
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (win_valid) state_d = ST_STALL;
      ST_STALL: begin
        if (!win_valid)        state_d = ST_IDLE;
        else if (bus.stall_ack) state_d = ST_JUMP;
      end
      ST_JUMP:    state_d = ST_SERVICE;
      ST_SERVICE: if (bus.eoi) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      hist_q  <= '0;
      pend_q  <= '0;
      id_q    <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      hist_q  <= bus.irq_src;
      pend_q  <= pend_d;
      // Vector address is registered only for the JUMP cycle and reads 0 otherwise.
      if ((state_q == ST_STALL) && (state_d == ST_JUMP)) begin
        id_q   <= win_id;
        addr_q <= VEC_BASE + (ADDR_WIDTH'(win_id) << VEC_STRIDE_LOG2);
      end else begin
        addr_q <= '0;
      end
    end
  end

  assign bus.stop        = (state_q == ST_STALL) || (state_q == ST_JUMP);
  assign bus.int_jump    = (state_q == ST_JUMP);
  assign bus.setINTR     = (state_q == ST_JUMP);
  assign bus.int_addr    = addr_q;
  assign bus.int_id      = id_q;
  assign bus.irq_pending = pend_q;

endmodule

// File: tb/tb_mbscore_vec_int_ctrl.sv
// tb/tb_mbscore_vec_int_ctrl.sv - directed self-checking bench for mbscore_vec_int_ctrl
// Purpose: drives directed interrupt scenarios and checks outputs cycle by cycle.
// Ports: none (top-level bench).
module tb_mbscore_vec_int_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  int   n_asserts = 0;
  int   n_fail    = 0;

  always #5 clk = ~clk;

  mbscore_vec_int_ctrl_if #(.NUM_SRC(8), .ADDR_WIDTH(32), .ID_WIDTH(3)) vif ();

  // Source 4 is level triggered, all others edge triggered.
  mbscore_vec_int_ctrl #(
    .NUM_SRC         (8),
    .ADDR_WIDTH      (32),
    .VEC_BASE        (32'h0000_0100),
    .VEC_STRIDE_LOG2 (4),
    .EDGE_MASK       (8'hEF),
    .ID_WIDTH        (3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (vif)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_eoi();
    vif.eoi = 1'b1;
    tick();
    vif.eoi = 1'b0;
  endtask

  initial begin
    rst_n         = 1'b0;
    vif.irq_src   = '0;
    vif.int_en_n  = 1'b0;
    vif.irq_mask  = '0;
    vif.stall_ack = 1'b0;
    vif.eoi       = 1'b0;
    tick();
    tick();
    check("rst_stop",    32'(vif.stop),        32'h0);
    check("rst_setintr", 32'(vif.setINTR),     32'h0);
    check("rst_jump",    32'(vif.int_jump),    32'h0);
    check("rst_addr",    vif.int_addr,         32'h0);
    check("rst_id",      32'(vif.int_id),      32'h0);
    check("rst_pending", 32'(vif.irq_pending), 32'h0);
    rst_n = 1'b1;
    tick();

    // Edge source 3, stall_ack tied high: minimum latency path.
    vif.stall_ack = 1'b1;
    vif.irq_src   = 8'h08;
    tick();
    check("s3_pend",  32'(vif.irq_pending), 32'h08);
    check("s3_stop0", 32'(vif.stop),        32'h0);
    vif.irq_src = 8'h00;
    tick();
    check("s3_stop1", 32'(vif.stop),     32'h1);
    check("s3_nojmp", 32'(vif.int_jump), 32'h0);
    tick();
    check("s3_jump",  32'(vif.int_jump), 32'h1);
    check("s3_set",   32'(vif.setINTR),  32'h1);
    check("s3_addr",  vif.int_addr,      32'h130);
    check("s3_id",    32'(vif.int_id),   32'h3);
    check("s3_stopj", 32'(vif.stop),     32'h1);
    tick();
    check("s3_jump0", 32'(vif.int_jump),    32'h0);
    check("s3_addr0", vif.int_addr,         32'h0);
    check("s3_stopf", 32'(vif.stop),        32'h0);
    check("s3_clr",   32'(vif.irq_pending), 32'h0);
    pulse_eoi();
    check("s3_idhold", 32'(vif.int_id), 32'h3);

    // Sources 5 and 2 together: 2 first, 5 after eoi.
    vif.irq_src = 8'h24;
    tick();
    check("p25_pend", 32'(vif.irq_pending), 32'h24);
    vif.irq_src = 8'h00;
    tick();
    check("p25_stop", 32'(vif.stop), 32'h1);
    tick();
    check("p2_jump", 32'(vif.int_jump), 32'h1);
    check("p2_addr", vif.int_addr,      32'h120);
    check("p2_id",   32'(vif.int_id),   32'h2);
    tick();
    check("p2_left5", 32'(vif.irq_pending), 32'h20);
    tick();
    tick();
    check("p2_nonest_stop", 32'(vif.stop),     32'h0);
    check("p2_nonest_jump", 32'(vif.int_jump), 32'h0);
    pulse_eoi();
    check("p5_idle_stop", 32'(vif.stop), 32'h0);
    tick();
    check("p5_stop", 32'(vif.stop), 32'h1);
    tick();
    check("p5_jump", 32'(vif.int_jump), 32'h1);
    check("p5_addr", vif.int_addr,      32'h150);
    check("p5_id",   32'(vif.int_id),   32'h5);
    tick();
    pulse_eoi();

    // Source 1 masked during STALL: back to IDLE, jump after unmask.
    vif.stall_ack = 1'b0;
    vif.irq_src   = 8'h02;
    tick();
    vif.irq_src = 8'h00;
    tick();
    check("m1_stop", 32'(vif.stop), 32'h1);
    vif.irq_mask = 8'h02;
    tick();
    check("m1_drop", 32'(vif.stop),     32'h0);
    check("m1_nojmp", 32'(vif.int_jump), 32'h0);
    tick();
    check("m1_idle", 32'(vif.stop),        32'h0);
    check("m1_pend", 32'(vif.irq_pending), 32'h02);
    vif.irq_mask  = 8'h00;
    vif.stall_ack = 1'b1;
    tick();
    check("m1_restall", 32'(vif.stop), 32'h1);
    tick();
    check("m1_jump", 32'(vif.int_jump), 32'h1);
    check("m1_addr", vif.int_addr,      32'h110);
    check("m1_id",   32'(vif.int_id),   32'h1);
    tick();
    pulse_eoi();

    // Level source 4 held through service: single entry until eoi, then again.
    vif.irq_src = 8'h10;
    tick();
    check("l4_pend", 32'(vif.irq_pending), 32'h10);
    tick();
    check("l4_stop", 32'(vif.stop), 32'h1);
    tick();
    check("l4_jump", 32'(vif.int_jump), 32'h1);
    check("l4_addr", vif.int_addr,      32'h140);
    tick();
    check("l4_forced", 32'(vif.irq_pending), 32'h0);
    tick();
    tick();
    check("l4_noreent_stop", 32'(vif.stop),     32'h0);
    check("l4_noreent_jump", 32'(vif.int_jump), 32'h0);
    pulse_eoi();
    tick();
    check("l4_pend2", 32'(vif.irq_pending), 32'h10);
    tick();
    check("l4_stop2", 32'(vif.stop), 32'h1);
    tick();
    check("l4_jump2", 32'(vif.int_jump), 32'h1);
    check("l4_addr2", vif.int_addr,      32'h140);
    check("l4_id2",   32'(vif.int_id),   32'h4);
    vif.irq_src = 8'h00;
    tick();
    pulse_eoi();
    tick();

    // Reset asserted in STALL while stall_ack is about to be sampled.
    vif.stall_ack = 1'b0;
    vif.irq_src   = 8'h40;
    tick();
    vif.irq_src = 8'h00;
    tick();
    check("r_stop", 32'(vif.stop), 32'h1);
    vif.stall_ack = 1'b1;
    rst_n         = 1'b0;
    #1;
    check("r_stop0", 32'(vif.stop),        32'h0);
    check("r_pend0", 32'(vif.irq_pending), 32'h0);
    check("r_id0",   32'(vif.int_id),      32'h0);
    check("r_addr0", vif.int_addr,         32'h0);
    tick();
    check("r_nojump", 32'(vif.int_jump), 32'h0);
    check("r_noset",  32'(vif.setINTR),  32'h0);
    rst_n         = 1'b1;
    vif.stall_ack = 1'b0;
    tick();
    check("r_after_stop", 32'(vif.stop),        32'h0);
    check("r_after_pend", 32'(vif.irq_pending), 32'h0);

    // Global disable: pending source waits, then jumps once enabled.
    vif.stall_ack = 1'b1;
    vif.int_en_n  = 1'b1;
    vif.irq_src   = 8'h01;
    tick();
    vif.irq_src = 8'h00;
    tick();
    check("g_stop_a", 32'(vif.stop), 32'h0);
    tick();
    check("g_stop_b", 32'(vif.stop),        32'h0);
    check("g_pend",   32'(vif.irq_pending), 32'h01);
    vif.int_en_n = 1'b0;
    tick();
    check("g_stop", 32'(vif.stop), 32'h1);
    tick();
    check("g_jump", 32'(vif.int_jump), 32'h1);
    check("g_addr", vif.int_addr,      32'h100);
    check("g_id",   32'(vif.int_id),   32'h0);
    tick();
    pulse_eoi();

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
